// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: forwarding select encodings and the
// per-stage control record kept by the shadow pipeline.
package pipe_ctrl_pkg;

    localparam int unsigned FWD_W   = 2;
    localparam logic [1:0]  FWD_RF  = 2'b00;
    localparam logic [1:0]  FWD_WB  = 2'b01;
    localparam logic [1:0]  FWD_MEM = 2'b10;

    // Control bits of one shadow stage; rd is held alongside, sized by REG_AW
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic is_load;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '{valid: 1'b0, regwrite: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/fwd_src_sel.sv
// Forwarding select for one EX source operand against the MEM and WB shadow
// stages. MEM wins over WB because it holds the younger value.
module fwd_src_sel
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic              mem_is_load,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              wb_valid,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    output logic [FWD_W-1:0]  sel
);

    logic rs_live;
    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so it never forwards; fall through to WB/regfile
    always_comb begin
        rs_live = rs_used & (rs != '0);
        mem_hit = rs_live & mem_valid & mem_regwrite & (mem_rd == rs) & ~mem_is_load;
        wb_hit  = rs_live & wb_valid & wb_regwrite & (wb_rd == rs);
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Load-use hazard detection, EX operand forwarding selects and a saturating
// stall counter, driven by a shadow copy of the EX/MEM/WB control fields.
module fwd_hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_cnt
);

    stage_ctrl_t               ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
    logic [REG_AW-1:0]         ex_rd_q, mem_rd_q, wb_rd_q;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_q;
    logic [NUM_SRC-1:0]        ex_rs_used_q;

    stage_ctrl_t               ex_ctrl_d;
    logic [REG_AW-1:0]         ex_rd_d;
    logic [NUM_SRC*REG_AW-1:0] ex_rs_d;
    logic [NUM_SRC-1:0]        ex_rs_used_d;

    logic [NUM_SRC-1:0]        src_hazard;
    logic                      ex_load_live;
    logic                      hazard;
    logic [2*NUM_SRC-1:0]      fwd_raw;
    logic [CNT_W-1:0]          stall_cnt_q;

    // WB load flag is tracked with the stage but no rule reads it
    logic unused_wb_is_load;
    assign unused_wb_is_load = wb_ctrl_q.is_load;

    assign ex_load_live = ex_ctrl_q.valid & ex_ctrl_q.regwrite & ex_ctrl_q.is_load &
                          (ex_rd_q != '0);

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // ID source g reads the register the EX load has not produced yet
        assign src_hazard[g] = id_rs_used[g] & (id_rs[g*REG_AW +: REG_AW] == ex_rd_q);

        fwd_src_sel #(
            .REG_AW(REG_AW)
        ) u_fwd_src_sel (
            .rs          (ex_rs_q[g*REG_AW +: REG_AW]),
            .rs_used     (ex_rs_used_q[g]),
            .mem_valid   (mem_ctrl_q.valid),
            .mem_regwrite(mem_ctrl_q.regwrite),
            .mem_is_load (mem_ctrl_q.is_load),
            .mem_rd      (mem_rd_q),
            .wb_valid    (wb_ctrl_q.valid),
            .wb_regwrite (wb_ctrl_q.regwrite),
            .wb_rd       (wb_rd_q),
            .sel         (fwd_raw[2*g +: 2])
        );
    end

    // Stall and forwarding outputs; reset forces both quiet while state clears
    always_comb begin
        hazard  = id_valid & ex_load_live & (|src_hazard);
        stall   = hazard & ~flush & ~rst;
        fwd_sel = rst ? '0 : fwd_raw;
    end

    // Next EX entry: the ID instruction on a normal cycle, a bubble on stall or flush
    always_comb begin
        ex_ctrl_d    = STAGE_BUBBLE;
        ex_rd_d      = '0;
        ex_rs_d      = '0;
        ex_rs_used_d = '0;
        if (!stall && !flush) begin
            ex_ctrl_d.valid    = id_valid;
            ex_ctrl_d.regwrite = id_regwrite;
            ex_ctrl_d.is_load  = id_is_load;
            ex_rd_d            = id_rd;
            ex_rs_d            = id_rs;
            ex_rs_used_d       = id_rs_used & {NUM_SRC{id_valid}};
        end
    end

    // Shadow pipeline advance; MEM and WB always shift
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q    <= STAGE_BUBBLE;
            mem_ctrl_q   <= STAGE_BUBBLE;
            wb_ctrl_q    <= STAGE_BUBBLE;
            ex_rd_q      <= '0;
            mem_rd_q     <= '0;
            wb_rd_q      <= '0;
            ex_rs_q      <= '0;
            ex_rs_used_q <= '0;
        end else begin
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rd_q      <= ex_rd_d;
            ex_rs_q      <= ex_rs_d;
            ex_rs_used_q <= ex_rs_used_d;
            mem_ctrl_q   <= ex_ctrl_q;
            mem_rd_q     <= ex_rd_q;
            wb_ctrl_q    <= mem_ctrl_q;
            wb_rd_q      <= mem_rd_q;
        end
    end

    // Saturating count of stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scenario bench for fwd_hazard_unit: default instance plus a NUM_SRC=3,
// CNT_W=4 instance for counter saturation and reset-mid-stall.
module tb_fwd_hazard_unit;

    typedef struct {
        logic       v;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       fl;
        logic       r;
    } stim_t;

    typedef struct {
        logic        stall;
        logic [5:0]  fwd;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_regwrite = 1'b0;
    logic        id_is_load = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cnt;

    logic        id3_valid = 1'b0;
    logic [14:0] id3_rs = '0;
    logic [2:0]  id3_rs_used = '0;
    logic [4:0]  id3_rd = '0;
    logic        id3_regwrite = 1'b0;
    logic        id3_is_load = 1'b0;
    logic        flush3 = 1'b0;
    logic        stall3;
    logic [5:0]  fwd3;
    logic [3:0]  cnt3;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rs_used (id_rs_used),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_is_load (id_is_load),
        .flush      (flush),
        .stall      (stall),
        .fwd_sel    (fwd_sel),
        .stall_cnt  (stall_cnt)
    );

    fwd_hazard_unit #(
        .NUM_SRC(3),
        .REG_AW (5),
        .CNT_W  (4)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id3_valid),
        .id_rs      (id3_rs),
        .id_rs_used (id3_rs_used),
        .id_rd      (id3_rd),
        .id_regwrite(id3_regwrite),
        .id_is_load (id3_is_load),
        .flush      (flush3),
        .stall      (stall3),
        .fwd_sel    (fwd3),
        .stall_cnt  (cnt3)
    );

    function automatic stim_t mk(input int v, input int rs0, input int rs1, input int used,
                                 input int rd, input int rw, input int ld, input int fl,
                                 input int r);
        stim_t s;
        s.v = v[0]; s.rs0 = rs0[4:0]; s.rs1 = rs1[4:0]; s.used = used[1:0];
        s.rd = rd[4:0]; s.rw = rw[0]; s.ld = ld[0]; s.fl = fl[0]; s.r = r[0];
        return s;
    endfunction

    function automatic exp_t ex(input int st, input int fwd, input int cnt);
        exp_t e;
        e.stall = st[0]; e.fwd = fwd[5:0]; e.cnt = cnt;
        return e;
    endfunction

    // Drive one ID-stage cycle just after the falling edge, then settle
    task automatic apply(input stim_t s);
        @(negedge clk);
        rst         = s.r;
        id_valid    = s.v;
        id_rs       = {s.rs1, s.rs0};
        id_rs_used  = s.used;
        id_rd       = s.rd;
        id_regwrite = s.rw;
        id_is_load  = s.ld;
        flush       = s.fl;
        #1;
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        st.push_back(mk(1, 5, 5, 3, 6, 1, 0, 0, 1)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 5, 3, 6, 1, 0, 0, 1)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 1, 0, 1, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL reset[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL reset[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL reset[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // add x5 ; add x6,x5,x7 -> MEM forward on source 0, no stall
    task automatic test_fwd_mem();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 2, 3, 5, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 7, 3, 6, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b000010, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL fwd_mem[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL fwd_mem[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL fwd_mem[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // lw x5 ; add x6,x5,x0 -> one stall, then WB forward
    task automatic test_load_use();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 2, 0, 1, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 0, 3, 6, 1, 0, 0, 0)); xp.push_back(ex(1, 0, 0));
        st.push_back(mk(1, 5, 0, 3, 6, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b000001, 1));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL load_use[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL load_use[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL load_use[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // add x5 ; add x5 ; sub x8,x5,x5 -> MEM beats WB on both sources
    task automatic test_mem_priority();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 2, 3, 5, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 3, 4, 3, 5, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 5, 3, 8, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b001010, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL mem_prio[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL mem_prio[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL mem_prio[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // lw x5 ; independent ; add x6,x5,x5 -> no stall, WB forward on both sources
    task automatic test_load_gap();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 1, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 1, 2, 3, 9, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 5, 3, 6, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b000101, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL load_gap[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL load_gap[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL load_gap[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // lw x0 then x0 reader; lw x5 then reader with rs_used=0 -> never stall or forward
    task automatic test_x0_unused();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 0, 0, 3, 6, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 1, 0, 1, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 5, 0, 7, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL x0_unused[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL x0_unused[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL x0_unused[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // lw x5 with source-1 dependant flushed in the same cycle -> no stall, EX bubble
    task automatic test_flush();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 1, 0, 1, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 1, 5, 2, 6, 1, 0, 1, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 1, 5, 2, 6, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b000100, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL flush[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL flush[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL flush[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // lw x5 ; lw x7,(x5) ; add x8,x7,x7 -> two separate one-cycle stalls
    task automatic test_back_to_back();
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(1, 0, 0, 0, 5, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 0));
        st.push_back(mk(1, 5, 0, 1, 7, 1, 1, 0, 0)); xp.push_back(ex(1, 0, 0));
        st.push_back(mk(1, 5, 0, 1, 7, 1, 1, 0, 0)); xp.push_back(ex(0, 0, 1));
        st.push_back(mk(1, 7, 7, 3, 8, 1, 0, 0, 0)); xp.push_back(ex(1, 6'b000001, 1));
        st.push_back(mk(1, 7, 7, 3, 8, 1, 0, 0, 0)); xp.push_back(ex(0, 0, 2));
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); xp.push_back(ex(0, 6'b000101, 2));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sb.push_back(xp[i]);
            e = sb.pop_front();
            checks++;
            if (stall !== e.stall) begin
                errors++; $display("FAIL b2b[%0d] stall: got %b want %b", i, stall, e.stall);
            end
            checks++;
            if ({2'b00, fwd_sel} !== e.fwd) begin
                errors++; $display("FAIL b2b[%0d] fwd_sel: got %b want %b", i, fwd_sel, e.fwd[3:0]);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL b2b[%0d] stall_cnt: got %0d want %0d", i, stall_cnt, e.cnt);
            end
        end
    endtask

    // 3-source, 4-bit counter: lw x5 whose source 2 is x5, held in ID.
    // It stalls every other cycle; 20 stalls saturate at 15, then reset mid-stall.
    task automatic test_saturate();
        exp_t e;
        exp_t got;
        int   half;
        do_reset();
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            rst          = (i == 41);
            id3_valid    = 1'b1;
            id3_rs       = {5'd5, 5'd0, 5'd0};
            id3_rs_used  = 3'b100;
            id3_rd       = 5'd5;
            id3_regwrite = 1'b1;
            id3_is_load  = 1'b1;
            flush3       = 1'b0;
            #1;
            half = i / 2;
            if (i <= 40) begin
                e.stall = i[0];
                e.fwd   = (i[0] && i >= 3) ? 6'b010000 : 6'b000000;
                e.cnt   = (half > 15) ? 32'd15 : 32'(half);
            end else if (i == 41) begin
                e = ex(0, 0, 15);
            end else if (i == 42) begin
                e = ex(0, 0, 0);
            end else begin
                e = ex(1, 0, 0);
            end
            sb.push_back(e);
            got = sb.pop_front();
            checks++;
            if (stall3 !== got.stall) begin
                errors++; $display("FAIL sat[%0d] stall: got %b want %b", i, stall3, got.stall);
            end
            checks++;
            if (fwd3 !== got.fwd) begin
                errors++; $display("FAIL sat[%0d] fwd_sel: got %b want %b", i, fwd3, got.fwd);
            end
            checks++;
            if ({28'd0, cnt3} !== got.cnt) begin
                errors++; $display("FAIL sat[%0d] stall_cnt: got %0d want %0d", i, cnt3, got.cnt);
            end
        end
        @(negedge clk);
        rst       = 1'b0;
        id3_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_mem();
        test_load_use();
        test_mem_priority();
        test_load_gap();
        test_x0_unused();
        test_flush();
        test_back_to_back();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, number of source-operand ports per instruction (legal 1..3).
REQ-002 Parameter REG_AW, default 5, register-address width; register 0 is hard-wired zero.
REQ-003 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs  in  NUM_SRC*REG_AW  ID source addresses; source i at bits [i*REG_AW +: REG_AW].
REQ-008 id_rs_used  in  NUM_SRC  per-source "operand actually read" qualifier.
REQ-009 id_rd  in  REG_AW  ID destination address.
REQ-010 id_regwrite  in  1  ID instruction writes id_rd.
REQ-011 id_is_load  in  1  ID instruction is a load (result available only in WB).
REQ-012 flush  in  1  EX-resolved redirect; kills the ID instruction.
REQ-013 stall  out  1  hold PC and IF/ID, insert bubble into EX.
REQ-014 fwd_sel  out  2*NUM_SRC  per EX source: 00 regfile, 10 from MEM, 01 from WB.
REQ-015 stall_cnt  out  CNT_W  cycles with stall=1, saturating.

Function
REQ-016 Unit keeps internal shadow stages EX, MEM, WB, each {valid, rd, regwrite, is_load}; EX also keeps rs[NUM_SRC], rs_used[NUM_SRC].
REQ-017 Normal cycle (stall=0, flush=0): EX<=ID fields with valid=id_valid; MEM<=EX; WB<=MEM.
REQ-018 Stall cycle: EX<=bubble (valid=0); MEM<=EX; WB<=MEM.
REQ-019 Flush cycle: EX<=bubble; MEM<=EX; WB<=MEM; ID fields discarded.
REQ-020 A stage "writes r" iff valid & regwrite & rd==r & r!=0.
REQ-021 Load-use hazard: id_valid & EX.is_load & EX writes id_rs[i] & id_rs_used[i] for any i.
REQ-022 stall = hazard & ~flush, combinational, zero latency; flush overrides stall.
REQ-023 A load stalls its dependant exactly one cycle; the dependant then forwards from WB.
REQ-024 fwd_sel[i] = 10 if EX.rs_used[i] & MEM writes EX.rs[i] & ~MEM.is_load.
REQ-025 Else fwd_sel[i] = 01 if EX.rs_used[i] & WB writes EX.rs[i].
REQ-026 Else fwd_sel[i] = 00; MEM priority over WB when both match (youngest value wins).
REQ-027 MEM-stage load matching an EX source never selects 10; falls through to WB/regfile rule.
REQ-028 fwd_sel is combinational from registered shadow state only; no path from id_* inputs.
REQ-029 Encoding 11 never driven.
REQ-030 stall_cnt increments by 1 each cycle stall=1; holds at all-ones.

Reset
REQ-031 rst=1 at a clock edge clears all shadow valid bits and stall_cnt to 0; rd/rs fields cleared to 0.
REQ-032 During and after reset, stall=0 and fwd_sel all 00 until valid instructions enter.
REQ-033 Reset mid-stall discards the pending hazard; first post-reset cycle issues no stall.

Structure
REQ-034 Shared package pipe_ctrl_pkg holds FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10 and the shadow-stage struct/width constants.
REQ-035 One sub-module fwd_src_sel (one source: rs, rs_used, MEM/WB entries -> 2-bit select) generated NUM_SRC times.
REQ-036 Hazard and counter logic live in the top module; no other sub-modules.

Verification
REQ-037 add x5 then add x6,x5,x7 back-to-back -> second in EX: fwd_sel[0]=10, stall never asserts.
REQ-038 lw x5 then add x6,x5,x0 -> stall=1 for exactly one cycle, stall_cnt=1; add in EX sees fwd_sel[0]=01.
REQ-039 add x5; add x5; sub x8,x5,x5 -> sub in EX: both sources 10 (MEM beats WB).
REQ-040 lw x0 then add using x0, and dependant with id_rs_used=0 -> stall=0, fwd_sel=00.
REQ-041 lw x5, dependant in ID, flush=1 same cycle -> stall=0, EX bubble, stall_cnt unchanged.
REQ-042 NUM_SRC=3, CNT_W=4: 20 forced load-use stalls, rst asserted mid-stall -> stall_cnt saturates at 15, then reads 0, stall=0 next cycle.
